sysid_checker: RTL and testbench

//   Avalon-MM master that reads the system-ID slave downstream of it and verifies
//   the ID word (addr 0) and the timestamp word (addr 1) against expected values.

---
 rtl/sysid_checker_pkg.sv | 25 ++
 rtl/sysid_read_port.sv | 66 ++++++
 rtl/sysid_checker.sv | 160 ++++++++++++++++
 tb/tb_sysid_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared types, addresses and width helpers for the system-ID checker.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    COMPARE,
    DONE
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COUNT_W = 16;

  // Bits needed for a counter spanning 0..n, never fewer than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sysid_read_port.sv
// Single Avalon-MM read: holds address/read through waitrequest, delays the
// data strobe by READ_LATENCY and aborts after TIMEOUT stalled cycles.
module sysid_read_port
  import sysid_checker_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              launch,
  input  logic              launch_addr,
  output logic              avm_address,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_timeout
);

  localparam int unsigned TW       = cnt_w(TIMEOUT);
  localparam int unsigned LW       = cnt_w(READ_LATENCY);
  localparam int unsigned LAT_LOAD = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

  logic [TW-1:0] wait_cnt;
  logic [LW-1:0] lat_cnt;
  logic          pending;
  logic          accept;

  // Data strobes are combinational so a zero-latency slave is captured on the accept cycle.
  assign accept     = avm_read && !avm_waitrequest;
  assign rd_timeout = avm_read && avm_waitrequest && (wait_cnt == TW'(TIMEOUT - 1));
  assign rd_valid   = (READ_LATENCY == 0) ? accept : (pending && (lat_cnt == '0));
  assign rd_data    = avm_readdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      wait_cnt    <= '0;
      lat_cnt     <= '0;
      pending     <= 1'b0;
    end else begin
      // A launch on the accept cycle chains straight into the next read.
      if (launch) begin
        avm_read    <= 1'b1;
        avm_address <= launch_addr;
        wait_cnt    <= '0;
      end else if (accept || rd_timeout) begin
        avm_read <= 1'b0;
      end else if (avm_read) begin
        wait_cnt <= wait_cnt + TW'(1);
      end

      if (accept && (READ_LATENCY != 0)) begin
        pending <= 1'b1;
        lat_cnt <= LW'(LAT_LOAD);
      end else if (pending) begin
        if (lat_cnt == '0) pending <= 1'b0;
        else               lat_cnt <= lat_cnt - LW'(1);
      end
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Reads and verifies the system-ID and timestamp words after reset, on start,
// or periodically, with retries, and reports the result to boot/health logic.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd11,
  parameter logic [31:0] EXPECTED_TS    = 32'd1447576925,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT        = 255,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter int unsigned RECHECK_PERIOD = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                avm_address,
  output logic                avm_read,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest,
  output logic [DATA_W-1:0]   id_value,
  output logic [DATA_W-1:0]   ts_value,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                mismatch_id,
  output logic                mismatch_ts,
  output logic                timeout,
  output logic [COUNT_W-1:0]  check_count
);

  localparam int unsigned RW = cnt_w(MAX_RETRIES);
  localparam int unsigned PW = cnt_w(RECHECK_PERIOD);

  state_e            state, next_state;
  logic              launch_c, launch_addr_c;
  logic              rd_valid, rd_timeout;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] id_cap, ts_cap;
  logic              att_timeout;
  logic [RW-1:0]     retry_cnt;
  logic [PW-1:0]     period_cnt;
  logic              auto_pend;
  logic              trigger_c, att_fail_c, retry_ok_c, id_bad_c, ts_bad_c;

  sysid_read_port #(
    .READ_LATENCY (READ_LATENCY),
    .TIMEOUT      (TIMEOUT)
  ) u_read_port (
    .clock           (clock),
    .reset           (reset),
    .launch          (launch_c),
    .launch_addr     (launch_addr_c),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .rd_timeout      (rd_timeout)
  );

  // A start coinciding with period expiry is one trigger, so it yields one check.
  assign trigger_c  = auto_pend || start || (period_cnt == PW'(1));
  assign id_bad_c   = !att_timeout && (id_cap != EXPECTED_ID);
  assign ts_bad_c   = !att_timeout && (ts_cap != EXPECTED_TS);
  assign att_fail_c = att_timeout || id_bad_c || ts_bad_c;
  assign retry_ok_c = (MAX_RETRIES != 0) && (retry_cnt != RW'(MAX_RETRIES));

  always_comb begin
    next_state    = state;
    launch_c      = 1'b0;
    launch_addr_c = ADDR_ID;
    case (state)
      IDLE: if (trigger_c) begin
        next_state = RD_ID;
        launch_c   = 1'b1;
      end
      RD_ID: begin
        if (rd_timeout) next_state = COMPARE;
        else if (rd_valid) begin
          next_state    = RD_TS;
          launch_c      = 1'b1;
          launch_addr_c = ADDR_TS;
        end else if (!avm_waitrequest) next_state = WAIT_ID;
      end
      WAIT_ID: if (rd_valid) begin
        next_state    = RD_TS;
        launch_c      = 1'b1;
        launch_addr_c = ADDR_TS;
      end
      RD_TS: begin
        if (rd_timeout || rd_valid) next_state = COMPARE;
        else if (!avm_waitrequest)  next_state = WAIT_TS;
      end
      WAIT_TS: if (rd_valid) next_state = COMPARE;
      COMPARE: begin
        if (att_fail_c && retry_ok_c) begin
          next_state = RD_ID;
          launch_c   = 1'b1;
        end else begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      auto_pend   <= 1'b1;
      id_cap      <= '0;
      ts_cap      <= '0;
      att_timeout <= 1'b0;
      retry_cnt   <= '0;
      period_cnt  <= '0;
      id_value    <= '0;
      ts_value    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      mismatch_id <= 1'b0;
      mismatch_ts <= 1'b0;
      timeout     <= 1'b0;
      check_count <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE) && (next_state != DONE);
      done  <= (next_state == DONE);

      if (state == IDLE) begin
        auto_pend <= 1'b0;
        if (period_cnt != '0) period_cnt <= period_cnt - PW'(1);
      end
      if (state == DONE) period_cnt <= PW'(RECHECK_PERIOD);

      if ((state == IDLE) && trigger_c)                retry_cnt <= '0;
      else if ((state == COMPARE) && (next_state == RD_ID)) retry_cnt <= retry_cnt + RW'(1);

      if (launch_c && (launch_addr_c == ADDR_ID)) att_timeout <= 1'b0;
      else if (rd_timeout)                        att_timeout <= 1'b1;

      if (rd_valid && ((state == RD_ID) || (state == WAIT_ID))) id_cap <= rd_data;
      if (rd_valid && ((state == RD_TS) || (state == WAIT_TS))) ts_cap <= rd_data;

      // Results become visible together with the done pulse.
      if (next_state == DONE) begin
        id_value    <= id_cap;
        ts_value    <= ts_cap;
        mismatch_id <= id_bad_c;
        mismatch_ts <= ts_bad_c;
        timeout     <= att_timeout;
        pass        <= !att_fail_c;
        if (check_count != '1) check_count <= check_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: instance A (L=0), B (L=2, stalls/reset),
// C (TIMEOUT=8, no retries, RECHECK_PERIOD=20), each with its own slave model.
`timescale 1ns/1ps
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd11;
  localparam logic [31:0] EXP_TS = 32'd1447576925;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic [2:0]  reset, start, address, read, waitrequest;
  logic [2:0]  busy, done, pass, mis_id, mis_ts, tmo;
  logic [31:0] readdata [3];
  logic [31:0] id_v [3];
  logic [31:0] ts_v [3];
  logic [15:0] cnt_v [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Slave A: zero latency, never stalls, ID word programmable.
  logic [31:0] id_a = EXP_ID;
  int          acc_a = 0;
  assign waitrequest[0] = 1'b0;
  assign readdata[0] = (read[0] && !waitrequest[0]) ? (address[0] ? EXP_TS : id_a) : JUNK;
  always @(posedge clock) if (read[0] && !waitrequest[0]) acc_a <= acc_a + 1;

  // Slave B: two-cycle read latency, optional 10-cycle stall on the timestamp read.
  logic        stall_b = 1'b0;
  int          stall_cnt_b = 0;
  int          ts_hold_b = 0;
  logic [31:0] p1_b = JUNK;
  logic [31:0] p2_b = JUNK;
  assign waitrequest[1] = read[1] && address[1] && stall_b && (stall_cnt_b < 10);
  assign readdata[1] = p2_b;
  always @(posedge clock) begin
    p1_b <= (read[1] && !waitrequest[1]) ? (address[1] ? EXP_TS : EXP_ID) : JUNK;
    p2_b <= p1_b;
    if (read[1] && address[1] && waitrequest[1]) stall_cnt_b <= stall_cnt_b + 1;
    if (read[1] && address[1]) ts_hold_b <= ts_hold_b + 1;
  end

  // Slave C: zero latency, waitrequest under bench control.
  logic wait_c = 1'b0;
  assign waitrequest[2] = wait_c;
  assign readdata[2] = (read[2] && !waitrequest[2]) ? (address[2] ? EXP_TS : EXP_ID) : JUNK;

  sysid_checker #(.READ_LATENCY(0), .TIMEOUT(255), .MAX_RETRIES(2), .RECHECK_PERIOD(0)) dut_a (
    .clock(clock), .reset(reset[0]), .start(start[0]),
    .avm_address(address[0]), .avm_read(read[0]), .avm_readdata(readdata[0]),
    .avm_waitrequest(waitrequest[0]), .id_value(id_v[0]), .ts_value(ts_v[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .mismatch_id(mis_id[0]),
    .mismatch_ts(mis_ts[0]), .timeout(tmo[0]), .check_count(cnt_v[0]));

  sysid_checker #(.READ_LATENCY(2), .TIMEOUT(255), .MAX_RETRIES(2), .RECHECK_PERIOD(0)) dut_b (
    .clock(clock), .reset(reset[1]), .start(start[1]),
    .avm_address(address[1]), .avm_read(read[1]), .avm_readdata(readdata[1]),
    .avm_waitrequest(waitrequest[1]), .id_value(id_v[1]), .ts_value(ts_v[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .mismatch_id(mis_id[1]),
    .mismatch_ts(mis_ts[1]), .timeout(tmo[1]), .check_count(cnt_v[1]));

  sysid_checker #(.READ_LATENCY(0), .TIMEOUT(8), .MAX_RETRIES(0), .RECHECK_PERIOD(20)) dut_c (
    .clock(clock), .reset(reset[2]), .start(start[2]),
    .avm_address(address[2]), .avm_read(read[2]), .avm_readdata(readdata[2]),
    .avm_waitrequest(waitrequest[2]), .id_value(id_v[2]), .ts_value(ts_v[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .mismatch_id(mis_id[2]),
    .mismatch_ts(mis_ts[2]), .timeout(tmo[2]), .check_count(cnt_v[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Counts negedges until done of instance idx; n is the cycle index of the DONE state.
  task automatic wait_done(input int idx, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      start = '0;
    end while (!done[idx] && n < limit);
    chk($sformatf("done%0d_seen", idx), 32'(done[idx]), 32'd1);
  endtask

  initial begin
    int   n;
    int   hi;
    int   a0;
    int   h0;
    logic seen;

    reset   = '1;
    start   = '0;
    stall_b = 1'b1;
    wait_c  = 1'b1;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 3; i++) begin
      chk("rst_read",  32'(read[i]), 32'd0);
      chk("rst_busy",  32'(busy[i]), 32'd0);
      chk("rst_done",  32'(done[i]), 32'd0);
      chk("rst_pass",  32'(pass[i]), 32'd0);
      chk("rst_count", 32'(cnt_v[i]), 32'd0);
    end

    // 1: automatic check after reset release, matching slave.
    a0 = acc_a;
    reset[0] = 1'b0;
    wait_done(0, 50, n);
    chk("t1_done_cycle", 32'(n), 32'd4);
    chk("t1_pass",  32'(pass[0]), 32'd1);
    chk("t1_count", 32'(cnt_v[0]), 32'd1);
    chk("t1_id",    id_v[0], EXP_ID);
    chk("t1_ts",    ts_v[0], EXP_TS);
    chk("t1_reads", 32'(acc_a - a0), 32'd2);

    // 2: wrong ID, two retries -> three attempts, six reads.
    @(negedge clock);
    id_a = 32'd12;
    a0 = acc_a;
    start[0] = 1'b1;
    wait_done(0, 60, n);
    chk("t2_done_cycle", 32'(n), 32'd10);
    chk("t2_reads",  32'(acc_a - a0), 32'd6);
    chk("t2_mis_id", 32'(mis_id[0]), 32'd1);
    chk("t2_mis_ts", 32'(mis_ts[0]), 32'd0);
    chk("t2_tmo",    32'(tmo[0]), 32'd0);
    chk("t2_pass",   32'(pass[0]), 32'd0);
    chk("t2_id",     id_v[0], 32'd12);
    chk("t2_count",  32'(cnt_v[0]), 32'd2);
    id_a = EXP_ID;

    // 3: L=2, timestamp read stalled ten cycles.
    h0 = ts_hold_b;
    reset[1] = 1'b0;
    wait_done(1, 60, n);
    chk("t3_done_cycle", 32'(n), 32'd18);
    chk("t3_stall_cycles", 32'(stall_cnt_b), 32'd10);
    chk("t3_ts_hold", 32'(ts_hold_b - h0), 32'd11);
    chk("t3_pass", 32'(pass[1]), 32'd1);
    chk("t3_ts",   ts_v[1], EXP_TS);

    // 5: reset during WAIT_TS, start pulses while busy are dropped.
    stall_b = 1'b0;
    @(negedge clock);
    start[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      start[1] = (k == 2);
    end
    chk("t5_wait_ts_read", 32'(read[1]), 32'd0);
    chk("t5_wait_ts_busy", 32'(busy[1]), 32'd1);
    reset[1] = 1'b1;
    @(negedge clock);
    chk("t5_rst_read",  32'(read[1]), 32'd0);
    chk("t5_rst_busy",  32'(busy[1]), 32'd0);
    chk("t5_rst_pass",  32'(pass[1]), 32'd0);
    chk("t5_rst_count", 32'(cnt_v[1]), 32'd0);
    chk("t5_rst_id",    id_v[1], 32'd0);
    reset[1] = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      start[1] = (n == 2) || (n == 6);
    end while (!done[1] && n < 40);
    start[1] = 1'b0;
    chk("t5_done_cycle", 32'(n), 32'd8);
    chk("t5_pass", 32'(pass[1]), 32'd1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clock);
      seen = seen | done[1];
    end
    chk("t5_no_extra_done", 32'(seen), 32'd0);
    chk("t5_count", 32'(cnt_v[1]), 32'd1);

    // 4: waitrequest stuck, TIMEOUT=8, no retries.
    reset[2] = 1'b0;
    hi = 0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (read[2]) hi++;
    end while (!done[2] && n < 60);
    chk("t4_done_cycle", 32'(n), 32'd10);
    chk("t4_read_cycles", 32'(hi), 32'd8);
    chk("t4_tmo",    32'(tmo[2]), 32'd1);
    chk("t4_pass",   32'(pass[2]), 32'd0);
    chk("t4_mis_id", 32'(mis_id[2]), 32'd0);
    chk("t4_mis_ts", 32'(mis_ts[2]), 32'd0);
    chk("t4_count",  32'(cnt_v[2]), 32'd1);

    // 6: periodic re-check every 20 idle cycles, counter saturation.
    wait_c = 1'b0;
    @(negedge clock);
    force dut_c.check_count = 16'hFFFD;
    @(negedge clock);
    release dut_c.check_count;
    wait_done(2, 60, n);
    chk("t6_period1", 32'(n + 2), 32'd24);
    chk("t6_count1",  32'(cnt_v[2]), 32'hFFFE);
    chk("t6_pass1",   32'(pass[2]), 32'd1);
    chk("t6_tmo1",    32'(tmo[2]), 32'd0);
    wait_done(2, 60, n);
    chk("t6_period2", 32'(n), 32'd24);
    chk("t6_count2",  32'(cnt_v[2]), 32'hFFFF);
    wait_done(2, 60, n);
    chk("t6_period3", 32'(n), 32'd24);
    chk("t6_count_sat", 32'(cnt_v[2]), 32'hFFFF);

    // Start coinciding with period expiry yields a single check.
    n = 0;
    do begin
      @(negedge clock);
      n++;
      start[2] = (n == 20);
    end while (!done[2] && n < 60);
    start[2] = 1'b0;
    chk("t6_coincide", 32'(n), 32'd24);
    wait_done(2, 60, n);
    chk("t6_single", 32'(n), 32'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
